// File: rtl/out_port_uart_tx.sv
// -----------------------------------------------------------------------------
// out_port_uart_tx
//   Output-port consumer for the SAP-1 OUT instruction. Every rising clock edge
//   with LO low captures the W-bus byte into a small FIFO. The FIFO drains
//   through an 8N1 UART transmitter on TXD, so the CPU never waits on the
//   serial link.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit (>= 2)
//   FIFO_DEPTH   : FIFO entries (power of 2, >= 2)
//   DATA_W       : captured word width; only DATA_IN[7:0] is transmitted
//
// Ports
//   clk     in   system clock, all state changes on posedge
//   rst     in   asynchronous active-low reset
//   LO      in   active-low output-load strobe (level-sensitive push)
//   DATA_IN in   W-bus word
//   TXD     out  registered serial line, idles high
//   BUSY    out  high while a frame is in START/DATA/STOP
//   EMPTY   out  FIFO holds no entries
//   FULL    out  FIFO holds FIFO_DEPTH entries
//   COUNT   out  FIFO occupancy
//   OVF     out  sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module out_port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          LO,
  input  logic [DATA_W-1:0]             DATA_IN,
  output logic                          TXD,
  output logic                          BUSY,
  output logic                          EMPTY,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          OVF
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [BAUD_W-1:0]  baud_r, baud_s;
  logic [2:0]         bit_r, bit_s;
  logic [7:0]         shift_r, shift_s;
  logic               txd_r, txd_s;
  logic               busy_r, busy_s;

  logic [7:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0]   rd_ptr_r, rd_ptr_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               empty_r, empty_s;
  logic               full_r, full_s;
  logic               ovf_r, ovf_s;

  logic               baud_end_s;
  logic               pop_s;
  logic               push_s;
  logic [7:0]         in_byte_s;

  // Only the low byte of a wider word is ever transmitted.
  assign in_byte_s = 8'(DATA_IN);

  assign TXD   = txd_r;
  assign BUSY  = busy_r;
  assign EMPTY = empty_r;
  assign FULL  = full_r;
  assign COUNT = count_r;
  assign OVF   = ovf_r;

  // Next-state logic for the transmitter FSM and the FIFO bookkeeping.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_s      = bit_r;
    shift_s    = shift_r;
    pop_s      = 1'b0;
    baud_end_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));

    case (state_r)
      IDLE: begin
        baud_s = {BAUD_W{1'b0}};
        bit_s  = 3'd0;
        if (!empty_r) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_s  = {BAUD_W{1'b0}};
          state_s = DATA;
        end else begin
          baud_s  = baud_r + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_s  = {BAUD_W{1'b0}};
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s  = baud_r + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_s = {BAUD_W{1'b0}};
          // A waiting byte starts immediately, giving no idle gap.
          if (!empty_r) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = {BAUD_W{1'b0}};
        bit_s   = 3'd0;
      end
    endcase

    // TXD is derived from the next state so the line itself is a flop output.
    case (state_s)
      IDLE:    txd_s = 1'b1;
      START:   txd_s = 1'b0;
      DATA:    txd_s = shift_s[0];
      STOP:    txd_s = 1'b1;
      default: txd_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);

    // A full FIFO that pops on this edge frees the slot the push needs.
    push_s = !LO && (!full_r || pop_s);
    ovf_s  = ovf_r || (!LO && full_r && !pop_s);

    if (push_s) begin
      wr_ptr_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
    empty_s = (count_s == CNT_W'(0));
    full_s  = (count_s == CNT_W'(FIFO_DEPTH));
  end

  // State, counters, flags and the TXD/BUSY output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      baud_r   <= {BAUD_W{1'b0}};
      bit_r    <= 3'd0;
      shift_r  <= 8'd0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      baud_r   <= baud_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
      txd_r    <= txd_s;
      busy_r   <= busy_s;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      empty_r  <= empty_s;
      full_r   <= full_s;
      ovf_r    <= ovf_s;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_byte_s;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule
